// File: rtl/vqe_link_pkg.sv
// Shared definitions for both ends of the byte-serial result link.
package vqe_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SRC,
        REQ,
        RECV,
        DONE
    } link_state_t;

    localparam int unsigned N_DEF       = 16;
    localparam int unsigned N_WORDS_DEF = 48;
    localparam int unsigned LAT_DEF     = 2;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/link_word_assembler.sv
// Captures link bytes, checks even parity and packs them MSB-first into words;
// raises a write strobe together with the completed word on its last byte.
module link_word_assembler
    import vqe_link_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic         i_clock,
    input  logic         i_reset_n,
    input  logic         capture,
    input  logic         last_byte,
    input  logic [7:0]   data_in,
    input  logic         parity_in,
    output logic         parity_bad,
    output logic         wr_en,
    output logic [N-1:0] wr_word
);

    logic [N-9:0] hold_q;
    logic [N-1:0] word_next;

    // Earlier bytes of the word sit in hold_q; the byte on the link completes it.
    assign word_next  = {hold_q, data_in};
    assign wr_word    = word_next;
    assign wr_en      = capture & last_byte;
    assign parity_bad = capture & (parity_in != even_parity(data_in));

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hold_q <= '0;
        end else if (capture) begin
            hold_q <= word_next[N-9:0];
        end
    end

endmodule

// File: rtl/psi_listener.sv
// Receiving end of the solver result link: request/handshake FSM, frame
// counters, local word array and a registered read port.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no frame in progress (after reset or abort)
// WAIT_SRC | frame requested locally, waiting for source_flag
// REQ      | listener_flag high, waiting for the link latency to elapse
// RECV     | one byte captured per cycle
// DONE     | full frame received, results held until the next i_start
module psi_listener
    import vqe_link_pkg::*;
#(
    parameter int unsigned N       = N_DEF,
    parameter int unsigned N_WORDS = N_WORDS_DEF,
    parameter int unsigned LAT     = LAT_DEF
) (
    input  logic         i_clock,
    input  logic         i_reset_n,
    input  logic         i_start,
    input  logic         source_flag,
    input  logic [7:0]   data_in,
    input  logic         parity_in,
    output logic         listener_flag,
    output logic         busy,
    output logic         done,
    output logic         err_parity,
    output logic         err_abort,
    output logic [6:0]   parity_err_count,
    output logic [5:0]   word_count,
    input  logic [5:0]   rd_addr,
    output logic [N-1:0] rd_data
);

    localparam int unsigned BYTES_PER_WORD = N / 8;
    localparam int unsigned TOTAL_BYTES    = N_WORDS * BYTES_PER_WORD;
    localparam logic [6:0]  LAST_BYTE      = 7'(TOTAL_BYTES - 1);
    localparam logic [3:0]  REQ_LOAD       = 4'(LAT - 2);

    link_state_t state_q, state_d;

    logic         capture;
    logic         clear_frame;
    logic         set_abort;
    logic         last_of_word;
    logic         parity_bad;
    logic         wr_en;
    logic [N-1:0] wr_word;
    logic [6:0]   byte_cnt_q;
    logic [3:0]   req_cnt_q;
    logic [N-1:0] mem_q [N_WORDS];

    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        clear_frame = 1'b0;
        set_abort   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (i_start) begin
                    state_d     = WAIT_SRC;
                    clear_frame = 1'b1;
                end
            end
            WAIT_SRC: begin
                if (source_flag) state_d = REQ;
            end
            REQ: begin
                if (!source_flag) begin
                    state_d   = IDLE;
                    set_abort = 1'b1;
                end else if (req_cnt_q == '0) begin
                    state_d = RECV;
                end
            end
            RECV: begin
                // A dropped source_flag wins over the byte on the link that cycle.
                if (!source_flag) begin
                    state_d   = IDLE;
                    set_abort = 1'b1;
                end else begin
                    capture = 1'b1;
                    if (byte_cnt_q == LAST_BYTE) state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q       <= IDLE;
            listener_flag <= 1'b0;
            req_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            listener_flag <= (state_d == REQ) || (state_d == RECV);
            if (state_q == WAIT_SRC) begin
                req_cnt_q <= REQ_LOAD;
            end else if (state_q == REQ && req_cnt_q != '0) begin
                req_cnt_q <= req_cnt_q - 4'd1;
            end
        end
    end

    assign busy = (state_q == WAIT_SRC) || (state_q == REQ) || (state_q == RECV);
    assign done = (state_q == DONE);

    assign last_of_word = (32'(byte_cnt_q) % BYTES_PER_WORD) == (BYTES_PER_WORD - 1);

    link_word_assembler #(
        .N (N)
    ) u_assembler (
        .i_clock    (i_clock),
        .i_reset_n  (i_reset_n),
        .capture    (capture),
        .last_byte  (last_of_word),
        .data_in    (data_in),
        .parity_in  (parity_in),
        .parity_bad (parity_bad),
        .wr_en      (wr_en),
        .wr_word    (wr_word)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            byte_cnt_q       <= '0;
            word_count       <= '0;
            parity_err_count <= '0;
            err_parity       <= 1'b0;
            err_abort        <= 1'b0;
        end else begin
            if (clear_frame) begin
                byte_cnt_q       <= '0;
                word_count       <= '0;
                parity_err_count <= '0;
                err_parity       <= 1'b0;
                err_abort        <= 1'b0;
            end
            if (capture) begin
                byte_cnt_q <= byte_cnt_q + 7'd1;
            end
            if (parity_bad) begin
                parity_err_count <= parity_err_count + 7'd1;
                err_parity       <= 1'b1;
            end
            if (wr_en) begin
                word_count <= word_count + 6'd1;
            end
            if (set_abort) begin
                err_abort <= 1'b1;
            end
        end
    end

    // Words from an aborted frame stay in place; only reset clears the array.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < int'(N_WORDS); i++) mem_q[i] <= '0;
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                mem_q[word_count] <= wr_word;
            end
            if (rd_addr < 6'(N_WORDS)) begin
                rd_data <= mem_q[rd_addr];
            end else begin
                rd_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_psi_listener.sv
// Self-checking bench for psi_listener: a behavioural sender drives frames with
// random words and parity faults; expectations come from a frame-level model.
module tb_psi_listener;

    localparam int NW  = 48;
    localparam int NB  = 96;
    localparam int LAT = 2;

    logic        shared_clock = 1'b0;
    logic        i_reset_n;
    logic        i_start;
    logic        source_flag;
    logic [7:0]  data_in;
    logic        parity_in;
    logic        listener_flag;
    logic        busy;
    logic        done;
    logic        err_parity;
    logic        err_abort;
    logic [6:0]  parity_err_count;
    logic [5:0]  word_count;
    logic [5:0]  rd_addr;
    logic [15:0] rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_mem [NW];

    always #5 shared_clock = ~shared_clock;

    psi_listener dut (
        .i_clock          (shared_clock),
        .i_reset_n        (i_reset_n),
        .i_start          (i_start),
        .source_flag      (source_flag),
        .data_in          (data_in),
        .parity_in        (parity_in),
        .listener_flag    (listener_flag),
        .busy             (busy),
        .done             (done),
        .err_parity       (err_parity),
        .err_abort        (err_abort),
        .parity_err_count (parity_err_count),
        .word_count       (word_count),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_listener"}, listener_flag, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err_parity"}, err_parity, 0);
        check({tag, "_err_abort"}, err_abort, 0);
        check({tag, "_pe_count"}, parity_err_count, 0);
        check({tag, "_word_count"}, word_count, 0);
        check({tag, "_rd_data"}, rd_data, 0);
    endtask

    task automatic check_mem();
        for (int a = 0; a < NW; a++) begin
            rd_addr = 6'(a);
            @(posedge shared_clock); #1;
            check("mem_word", rd_data, exp_mem[a]);
        end
        rd_addr = 6'd48;
        @(posedge shared_clock); #1;
        check("rd_addr_48", rd_data, 0);
        rd_addr = 6'($urandom_range(63, 49));
        @(posedge shared_clock); #1;
        check("rd_addr_high", rd_data, 0);
    endtask

    // One frame from i_start to completion / abort / reset. Negative k disables an option.
    task automatic run_frame(input int abort_k, input int reset_k, input int pulse_k,
                             input int probe_w, input bit pattern, input int n_rand_flip,
                             input bit flip_0_57);
        logic [15:0] w [NW];
        bit          flip [NB];
        logic [15:0] cur;
        int          cycles;
        int          captured;
        int          exp_pe;
        int          src_delay;

        for (int i = 0; i < NW; i++) w[i] = pattern ? {8'(i), 8'(i)} : 16'($urandom);
        for (int k = 0; k < NB; k++) flip[k] = 1'b0;
        if (flip_0_57) begin
            flip[0]  = 1'b1;
            flip[57] = 1'b1;
        end
        for (int j = 0; j < n_rand_flip; j++) flip[$urandom_range(NB - 1, 0)] = 1'b1;

        src_delay   = $urandom_range(2, 0);
        i_start     = 1'b1;
        source_flag = (src_delay == 0);
        @(posedge shared_clock); #1;
        i_start = 1'b0;
        check("start_busy", busy, 1);
        check("start_done_clr", done, 0);
        check("start_wc_clr", word_count, 0);
        check("start_pe_clr", parity_err_count, 0);
        check("start_errp_clr", err_parity, 0);
        check("start_erra_clr", err_abort, 0);
        for (int d = 0; d < src_delay; d++) begin
            check("wait_listener_low", listener_flag, 0);
            @(posedge shared_clock); #1;
        end
        source_flag = 1'b1;

        cycles = 0;
        while (listener_flag !== 1'b1 && cycles < 8) begin
            @(posedge shared_clock); #1;
            cycles++;
        end
        check("req_latency", cycles, 1);
        if (listener_flag !== 1'b1) begin
            source_flag = 1'b0;
            return;
        end

        repeat (LAT - 1) begin
            @(posedge shared_clock); #1;
        end

        captured = NB;
        for (int k = 0; k < NB; k++) begin
            cur       = w[k / 2];
            data_in   = (k % 2 == 0) ? cur[15:8] : cur[7:0];
            parity_in = (^data_in) ^ flip[k];
            if (k == pulse_k) i_start = 1'b1;
            if (k == 2 * probe_w + 1) rd_addr = 6'(probe_w);
            @(posedge shared_clock); #1;
            i_start = 1'b0;
            if (k == 2 * probe_w + 1) check("same_edge_read_old", rd_data, exp_mem[probe_w]);
            if (k % 16 == 5) check("wc_progress", word_count, (k + 1) / 2);
            if (k == 0) check("listener_in_recv", listener_flag, 1);
            if (k == NB - 2) check("done_not_early", done, 0);
            if (k == reset_k) begin
                i_reset_n   = 1'b0;
                source_flag = 1'b0;
                #1;
                check_all_zero("async_reset");
                for (int i = 0; i < NW; i++) exp_mem[i] = '0;
                @(negedge shared_clock);
                i_reset_n = 1'b1;
                @(posedge shared_clock); #1;
                check("post_reset_listener", listener_flag, 0);
                return;
            end
            if (k == abort_k) begin
                source_flag = 1'b0;
                @(posedge shared_clock); #1;
                captured = k + 1;
                break;
            end
        end
        source_flag = 1'b0;

        exp_pe = 0;
        for (int k = 0; k < captured; k++) if (flip[k]) exp_pe++;
        for (int i = 0; i < captured / 2; i++) exp_mem[i] = w[i];

        check("end_word_count", word_count, captured / 2);
        check("end_pe_count", parity_err_count, exp_pe);
        check("end_err_parity", err_parity, exp_pe > 0);
        check("end_err_abort", err_abort, captured < NB);
        check("end_done", done, captured == NB);
        check("end_listener_low", listener_flag, 0);
        check("end_busy", busy, 0);
    endtask

    initial begin
        i_reset_n   = 1'b0;
        i_start     = 1'b0;
        source_flag = 1'b0;
        data_in     = '0;
        parity_in   = 1'b0;
        rd_addr     = '0;
        for (int i = 0; i < NW; i++) exp_mem[i] = '0;
        #12;
        check_all_zero("reset");
        @(negedge shared_clock);
        i_reset_n = 1'b1;
        @(posedge shared_clock); #1;
        check_mem();

        // Clean counting pattern, then direct read of word 5.
        run_frame(-1, -1, -1, 5, 1'b1, 0, 1'b0);
        rd_addr = 6'd5;
        @(posedge shared_clock); #1;
        check("word5_pattern", rd_data, 16'h0505);
        check_mem();

        // Parity faults on bytes 0 and 57; i_start here also exercises the DONE exit.
        run_frame(-1, -1, -1, $urandom_range(NW - 1, 0), 1'b0, 0, 1'b1);
        check("parity_two", parity_err_count, 2);
        check_mem();

        run_frame(-1, -1, -1, $urandom_range(NW - 1, 0), 1'b0, $urandom_range(6, 1), 1'b0);
        check_mem();

        // Abort after byte 20 leaves 10 complete words.
        run_frame(20, -1, -1, -1, 1'b0, 0, 1'b0);
        check("abort_words", word_count, 10);
        check_mem();

        run_frame(-1, 40, -1, -1, 1'b0, 1, 1'b0);
        check_mem();
        run_frame(-1, -1, -1, -1, 1'b1, 0, 1'b0);
        check_mem();

        // i_start pulsed mid-RECV must be ignored.
        run_frame(-1, -1, 30, -1, 1'b0, 2, 1'b0);
        check_mem();

        repeat (3) begin
            run_frame($urandom_range(NB - 2, 0), -1, -1, -1, 1'b0, $urandom_range(4, 0), 1'b0);
            check_mem();
        end
        run_frame(-1, -1, -1, $urandom_range(NW - 1, 0), 1'b0, $urandom_range(4, 0), 1'b0);
        check_mem();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
